// File: rtl/bus_pkg.sv
// Shared types and memory-map constants for the memory bus controller
// and for the other blocks that decode addresses.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } bus_state_t;

    localparam int WAIT_W = 4;

    localparam logic [63:0] IM_BASE = 64'h0000;
    localparam logic [63:0] IM_SIZE = 64'h2000;
    localparam logic [63:0] DM_BASE = 64'h2000;
    localparam logic [63:0] DM_SIZE = 64'h1000;

    // Region index width, kept at least one bit so a single-region map still has a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_addr_decoder.sv
// Combinational region-map decoder: finds the lowest-indexed region that
// contains addr and reports the region-relative offset.
module mem_addr_decoder
    import bus_pkg::*;
#(
    parameter int                        ADDR_W   = 64,
    parameter int                        N_REG    = 2,
    parameter logic [N_REG*ADDR_W-1:0]   REG_BASE = {DM_BASE, IM_BASE},
    parameter logic [N_REG*ADDR_W-1:0]   REG_SIZE = {DM_SIZE, IM_SIZE},
    parameter logic [N_REG-1:0]          RO_MASK  = 2'b01,
    localparam int                       IDX_W    = idx_width(N_REG)
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    output logic              hit,
    output logic [IDX_W-1:0]  idx,
    output logic              ro_violation,
    output logic [ADDR_W-1:0] offset
);

    logic [N_REG-1:0] region_hit;

    // One extra bit on both sides so base+size at the top of the space does not wrap to 0.
    generate
        for (genvar gi = 0; gi < N_REG; gi++) begin : g_region
            logic [ADDR_W:0] base_ext;
            logic [ADDR_W:0] end_ext;
            assign base_ext = {1'b0, REG_BASE[gi*ADDR_W +: ADDR_W]};
            assign end_ext  = base_ext + {1'b0, REG_SIZE[gi*ADDR_W +: ADDR_W]};
            assign region_hit[gi] = ({1'b0, addr} >= base_ext) && ({1'b0, addr} < end_ext);
        end
    endgenerate

    // Scanning from the top down lets the lowest matching index win on overlap.
    always_comb begin
        hit          = 1'b0;
        idx          = '0;
        ro_violation = 1'b0;
        offset       = '0;
        for (int i = N_REG - 1; i >= 0; i--) begin
            if (region_hit[i]) begin
                hit          = 1'b1;
                idx          = IDX_W'(i);
                ro_violation = we && RO_MASK[i];
                offset       = addr - REG_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/mem_bus_sys.sv
// System-level wrapper: instruction memory as read-only region 0 and
// data memory as region 1, using the standard map and wait states.
module mem_bus_sys
    import bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy,
    output logic        im_sel,
    output logic        dm_sel,
    output logic        s_we,
    output logic [63:0] s_addr,
    output logic [63:0] s_wdata,
    input  logic [63:0] im_rdata,
    input  logic [63:0] dm_rdata
);

    logic [1:0] s_sel;

    mem_bus_ctrl #(
        .ADDR_W   (64),
        .DATA_W   (64),
        .N_REG    (2),
        .REG_BASE ({DM_BASE, IM_BASE}),
        .REG_SIZE ({DM_SIZE, IM_SIZE}),
        .REG_WAIT ({4'd1, 4'd0}),
        .RO_MASK  (2'b01)
    ) u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready),
        .err     (err),
        .busy    (busy),
        .s_sel   (s_sel),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata ({dm_rdata, im_rdata})
    );

    assign im_sel = s_sel[0];
    assign dm_sel = s_sel[1];

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-space controller: steers the datapath memory port to one of N
// slave regions with per-region wait states, write protection and errors.
module mem_bus_ctrl
    import bus_pkg::*;
#(
    parameter int                        ADDR_W   = 64,
    parameter int                        DATA_W   = 64,
    parameter int                        N_REG    = 2,
    parameter logic [N_REG*ADDR_W-1:0]   REG_BASE = {DM_BASE, IM_BASE},
    parameter logic [N_REG*ADDR_W-1:0]   REG_SIZE = {DM_SIZE, IM_SIZE},
    parameter logic [N_REG*WAIT_W-1:0]   REG_WAIT = {4'd1, 4'd0},
    parameter logic [N_REG-1:0]          RO_MASK  = 2'b01
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    ready,
    output logic                    err,
    output logic                    busy,
    output logic [N_REG-1:0]        s_sel,
    output logic                    s_we,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W-1:0]       s_wdata,
    input  logic [N_REG*DATA_W-1:0] s_rdata
);

    localparam int IDX_W = idx_width(N_REG);

    bus_state_t        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              we_q, we_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [N_REG-1:0]  s_sel_q, s_sel_d;
    logic              s_we_q, s_we_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic              dec_ro;
    logic [ADDR_W-1:0] dec_offset;
    logic [WAIT_W-1:0] wait_sel;
    logic [N_REG-1:0]  sel_onehot;
    logic [DATA_W-1:0] slave_rdata;

    mem_addr_decoder #(
        .ADDR_W   (ADDR_W),
        .N_REG    (N_REG),
        .REG_BASE (REG_BASE),
        .REG_SIZE (REG_SIZE),
        .RO_MASK  (RO_MASK)
    ) u_decoder (
        .addr         (addr),
        .we           (we),
        .hit          (dec_hit),
        .idx          (dec_idx),
        .ro_violation (dec_ro),
        .offset       (dec_offset)
    );

    always_comb begin
        wait_sel    = '0;
        sel_onehot  = '0;
        slave_rdata = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (dec_idx == IDX_W'(i)) begin
                wait_sel      = REG_WAIT[i*WAIT_W +: WAIT_W];
                sel_onehot[i] = 1'b1;
            end
            if (idx_q == IDX_W'(i)) begin
                slave_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        we_d      = we_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        s_sel_d   = s_sel_q;
        s_we_d    = 1'b0;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        rdata_d   = rdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!dec_hit || dec_ro) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = ACCESS;
                        cnt_d     = wait_sel;
                        idx_d     = dec_idx;
                        we_d      = we;
                        s_sel_d   = sel_onehot;
                        s_addr_d  = dec_offset;
                        s_wdata_d = wdata;
                        // Strobe is registered, so it is raised one edge ahead of the last ACCESS cycle.
                        s_we_d    = we && (wait_sel == '0);
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    s_sel_d = '0;
                    if (!we_q) begin
                        rdata_d = slave_rdata;
                    end
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    s_we_d = we_q && (cnt_q == WAIT_W'(1));
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            s_sel_q   <= '0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            s_sel_q   <= s_sel_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign busy    = (state_q != IDLE);
    assign s_sel   = s_sel_q;
    assign s_we    = s_we_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: three regions (IM read-only, DM, and
// a region at the very top of the 64-bit space) with wait states 0/1/3.
module tb_mem_bus_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req = 1'b0;
    logic         we = 1'b0;
    logic [63:0]  addr = '0;
    logic [63:0]  wdata = '0;
    logic [63:0]  rdata;
    logic         ready;
    logic         err;
    logic         busy;
    logic [2:0]   s_sel;
    logic         s_we;
    logic [63:0]  s_addr;
    logic [63:0]  s_wdata;
    logic [191:0] s_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
        logic [2:0]  sel;
        logic [63:0] saddr;
        int          lat;
        int          acc;
        int          issue;
    } exp_t;

    typedef struct {
        logic [2:0]  sel;
        logic [63:0] saddr;
        logic [63:0] data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    mem_bus_ctrl #(
        .ADDR_W   (64),
        .DATA_W   (64),
        .N_REG    (3),
        .REG_BASE ({64'hFFFF_FFFF_FFFF_F000, 64'h2000, 64'h0}),
        .REG_SIZE ({64'h1000, 64'h1000, 64'h2000}),
        .REG_WAIT ({4'd3, 4'd1, 4'd0}),
        .RO_MASK  (3'b001)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready),
        .err     (err),
        .busy    (busy),
        .s_sel   (s_sel),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Combinational slaves: distinct tag per slave plus the offset, and one instruction word.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slave
            assign s_rdata[gi*64 +: 64] = (gi == 0 && s_addr == 64'h10) ? 64'h0000_0000_0050_0093
                                          : {8'hA0 + 8'(gi), 24'h0, s_addr[31:0]};
        end
    endgenerate

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            acc_cnt = 0;
        end else begin
            if (s_sel != 3'b000) begin
                acc_cnt++;
                chk("busy_in_access", 64'(busy), 64'd1);
                if (exp_q.size() == 0) note_fail("access_without_request");
                else begin
                    chk("s_sel", 64'(s_sel), 64'(exp_q[0].sel));
                    chk("s_addr", s_addr, exp_q[0].saddr);
                end
            end
            if (s_we) begin
                if (wr_q.size() == 0) note_fail("unexpected_s_we");
                else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_sel", 64'(s_sel), 64'(w.sel));
                    chk("wr_addr", s_addr, w.saddr);
                    chk("wr_data", s_wdata, w.data);
                    if (exp_q.size() != 0) chk("s_we_cycle", 64'(acc_cnt), 64'(exp_q[0].acc));
                end
            end
            if (ready) begin
                if (exp_q.size() == 0) note_fail("unexpected_ready");
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("err", 64'(err), 64'(e.err));
                    chk("rdata", rdata, e.rdata);
                    chk("latency", 64'(cyc - e.issue), 64'(e.lat));
                    chk("access_cycles", 64'(acc_cnt), 64'(e.acc));
                    $display("txn done: err=%0b rdata=0x%0h latency=%0d access_cycles=%0d",
                             err, rdata, cyc - e.issue, acc_cnt);
                end
                acc_cnt = 0;
            end
        end
    end

    task automatic push_exp(input logic w, input logic [63:0] d, input logic e, input logic [2:0] sel,
                            input logic [63:0] sa, input int wt, input logic [63:0] rd, input int iss);
        exp_t x;
        wr_t  y;
        x.err = e; x.rdata = rd; x.sel = sel; x.saddr = sa;
        x.lat = e ? 1 : wt + 2;
        x.acc = e ? 0 : wt + 1;
        x.issue = iss;
        exp_q.push_back(x);
        if (w && !e) begin
            y.sel = sel; y.saddr = sa; y.data = d;
            wr_q.push_back(y);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && !ready) return;
        end
        note_fail("wait_idle_timeout");
    endtask

    task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d, input logic e,
                         input logic [2:0] sel, input logic [63:0] sa, input int wt, input logic [63:0] rd);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        push_exp(w, d, e, sel, sa, wt, rd, cyc);
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_ready", 64'(ready), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_s_sel", 64'(s_sel), 64'h0);
        reset = 1'b1;

        //     we    addr                    wdata                   err   sel     s_addr   W  rdata
        issue(1'b0, 64'h10,                 64'h0,                  1'b0, 3'b001, 64'h10,  0, 64'h0000_0000_0050_0093);
        issue(1'b1, 64'h2008,               64'hDEAD_BEEF,          1'b0, 3'b010, 64'h8,   1, 64'h0000_0000_0050_0093);
        issue(1'b1, 64'h4,                  64'h1111,               1'b1, 3'b000, 64'h0,   0, 64'h0000_0000_0050_0093);
        issue(1'b0, 64'h3000,               64'h0,                  1'b1, 3'b000, 64'h0,   0, 64'h0000_0000_0050_0093);
        issue(1'b0, 64'h1FFF,               64'h0,                  1'b0, 3'b001, 64'h1FFF,0, 64'hA000_0000_0000_1FFF);
        issue(1'b0, 64'h2000,               64'h0,                  1'b0, 3'b010, 64'h0,   1, 64'hA100_0000_0000_0000);
        issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                 1'b0, 3'b100, 64'hFFF, 3, 64'hA200_0000_0000_0FFF);
        issue(1'b0, 64'h0,                  64'h0,                  1'b0, 3'b001, 64'h0,   0, 64'hA000_0000_0000_0000);
        issue(1'b0, 64'hFFFF_FFFF_FFFF_EFFF, 64'h0,                 1'b1, 3'b000, 64'h0,   0, 64'hA000_0000_0000_0000);
        issue(1'b1, 64'hFFFF_FFFF_FFFF_F100, 64'h1234_5678_9ABC_DEF0, 1'b0, 3'b100, 64'h100, 3, 64'hA000_0000_0000_0000);

        // Reset inside the first ACCESS cycle of a W=3 write: no expectation is queued for it.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 64'hFFFF_FFFF_FFFF_F200; wdata = 64'h5555;
        @(posedge clk);
        #2 reset = 1'b0; req = 1'b0;
        #1;
        chk("mid_rst_rdata", rdata, 64'h0);
        chk("mid_rst_ready", 64'(ready), 64'h0);
        chk("mid_rst_err", 64'(err), 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_s_sel", 64'(s_sel), 64'h0);
        chk("mid_rst_s_we", 64'(s_we), 64'h0);
        chk("mid_rst_s_addr", s_addr, 64'h0);
        chk("mid_rst_s_wdata", s_wdata, 64'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        issue(1'b0, 64'h10, 64'h0, 1'b0, 3'b001, 64'h10, 0, 64'h0000_0000_0050_0093);

        // A req pulse in the middle of ACCESS must be dropped.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 64'h2010;
        push_exp(1'b0, 64'h0, 1'b0, 3'b010, 64'h10, 1, 64'hA100_0000_0000_0010, cyc);
        @(posedge clk);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 64'h4;
        @(negedge clk);
        req = 1'b0;
        wait_idle();

        // Held req: one completion every W+3 = 4 cycles.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 64'h2018;
        for (int k = 0; k < 3; k++)
            push_exp(1'b0, 64'h0, 1'b0, 3'b010, 64'h18, 1, 64'hA100_0000_0000_0018, cyc + 4 * k);
        repeat (10) @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        wait_idle();

        repeat (4) @(negedge clk);
        chk("pending_responses", 64'(exp_q.size()), 64'd0);
        chk("pending_writes", 64'(wr_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
